// File: rtl/cordic_share_arb_if.sv
// Client/core bundle for the shared CORDIC arbiter.
// slave = arbiter side, master = clients plus core instances.
interface cordic_share_arb_if #(
  parameter int NC          = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16
);
  logic [NC-1:0]             req;
  logic [NC-1:0]             gnt;
  logic [NC-1:0]             c_vec_en;
  logic [NC*DATA_WIDTH-1:0]  c_vec_xin;
  logic [NC*DATA_WIDTH-1:0]  c_vec_yin;
  logic [NC-1:0]             c_vec_angle_calc_en;
  logic [NC-1:0]             c_rot_en;
  logic [NC*DATA_WIDTH-1:0]  c_rot_xin;
  logic [NC*DATA_WIDTH-1:0]  c_rot_yin;
  logic [NC*ANGLE_WIDTH-1:0] c_rot_angle_in;
  logic [NC-1:0]             c_rot_angle_microRot_n;
  logic [NC*2-1:0]           c_rot_quad_in;
  logic                      vec_en;
  logic [DATA_WIDTH-1:0]     vec_xin;
  logic [DATA_WIDTH-1:0]     vec_yin;
  logic                      vec_angle_calc_en;
  logic                      rot_en;
  logic [DATA_WIDTH-1:0]     rot_xin;
  logic [DATA_WIDTH-1:0]     rot_yin;
  logic [ANGLE_WIDTH-1:0]    rot_angle_in;
  logic                      rot_angle_microRot_n;
  logic [1:0]                rot_quad_in;
  logic                      vec_opvld_in;
  logic                      rot_opvld_in;
  logic [NC-1:0]             c_vec_opvld;
  logic [NC-1:0]             c_rot_opvld;
  logic                      busy;
  logic [2:0]                err;

  modport slave (
    input  req, c_vec_en, c_vec_xin, c_vec_yin,
    input  c_vec_angle_calc_en, c_rot_en,
    input  c_rot_xin, c_rot_yin, c_rot_angle_in,
    input  c_rot_angle_microRot_n, c_rot_quad_in,
    input  vec_opvld_in, rot_opvld_in,
    output gnt, vec_en, vec_xin, vec_yin,
    output vec_angle_calc_en, rot_en,
    output rot_xin, rot_yin, rot_angle_in,
    output rot_angle_microRot_n, rot_quad_in,
    output c_vec_opvld, c_rot_opvld, busy, err
  );

  modport master (
    output req, c_vec_en, c_vec_xin, c_vec_yin,
    output c_vec_angle_calc_en, c_rot_en,
    output c_rot_xin, c_rot_yin, c_rot_angle_in,
    output c_rot_angle_microRot_n, c_rot_quad_in,
    output vec_opvld_in, rot_opvld_in,
    input  gnt, vec_en, vec_xin, vec_yin,
    input  vec_angle_calc_en, rot_en,
    input  rot_xin, rot_yin, rot_angle_in,
    input  rot_angle_microRot_n, rot_quad_in,
    input  c_vec_opvld, c_rot_opvld, busy, err
  );
endinterface

// File: rtl/cordic_share_arb.sv
// Round-robin session arbiter sharing one vectoring and one rotation CORDIC.
// Define ARB_TIMEOUT_EN to add a DRAIN watchdog (TIMEOUT cycles).
module cordic_share_arb #(
  parameter int NC          = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int CNT_WIDTH   = 5,
  parameter int TIMEOUT     = 1023
) (
  input logic              clk,
  input logic              rst_n,
  cordic_share_arb_if.slave bus
);
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [CNT_WIDTH-1:0] CMAX = {CNT_WIDTH{1'b1}};

  if (NC < 2 || NC > 4 || TIMEOUT < 1) begin : g_cfg_chk
    $error("cordic_share_arb: unsupported NC or TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t               state, state_nx;
  logic [IW-1:0]        owner, owner_nx;
  logic [IW-1:0]        last_owner, last_nx;
  logic [IW-1:0]        pick, cand;
  logic                 found;
  logic [NC-1:0]        gnt_nx, own;
  logic [CNT_WIDTH-1:0] vec_cnt, rot_cnt;
  logic [CNT_WIDTH-1:0] vec_cnt_nx, rot_cnt_nx;
  logic [2:0]           err_nx;
  logic                 active, vec_iss, rot_iss;
  logic                 vec_ret, rot_ret, timeout, wd_fire;

  assign active  = (state != IDLE);
  assign own     = active ? bus.gnt : '0;
  assign vec_iss = active && bus.c_vec_en[owner];
  assign rot_iss = active && bus.c_rot_en[owner];
  assign vec_ret = bus.vec_opvld_in && (vec_cnt != '0);
  assign rot_ret = bus.rot_opvld_in && (rot_cnt != '0);

  assign bus.busy        = active;
  assign bus.c_vec_opvld = vec_ret ? bus.gnt : '0;
  assign bus.c_rot_opvld = rot_ret ? bus.gnt : '0;

  always_comb begin
    pick  = last_owner;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NC; k++) begin
      cand = IW'((int'(last_owner) + k) % NC);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd <= '0;
    else if (state == DRAIN && state_nx == DRAIN) wd <= wd + 1'b1;
    else wd <= '0;
  end

  assign timeout = (state == DRAIN) && (wd == WW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last_owner;
    gnt_nx   = bus.gnt;
    wd_fire  = 1'b0;
    unique case (state)
      IDLE: if (found) begin
        state_nx = GRANT;
        owner_nx = pick;
        gnt_nx   = NC'(1) << pick;
      end
      GRANT: if (!bus.req[owner]) state_nx = DRAIN;
      DRAIN: begin
        if (bus.req[owner]) begin
          state_nx = GRANT;
        end else if (vec_cnt == '0 && rot_cnt == '0) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          last_nx  = owner;
        end else if (timeout) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          last_nx  = owner;
          wd_fire  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // saturated counters hold; returns at zero are dropped
    vec_cnt_nx = vec_cnt;
    if (vec_iss && !vec_ret && vec_cnt != CMAX) vec_cnt_nx = vec_cnt + 1'b1;
    else if (!vec_iss && vec_ret) vec_cnt_nx = vec_cnt - 1'b1;
    rot_cnt_nx = rot_cnt;
    if (rot_iss && !rot_ret && rot_cnt != CMAX) rot_cnt_nx = rot_cnt + 1'b1;
    else if (!rot_iss && rot_ret) rot_cnt_nx = rot_cnt - 1'b1;
    if (wd_fire) begin
      vec_cnt_nx = '0;
      rot_cnt_nx = '0;
    end

    err_nx    = bus.err;
    err_nx[0] = bus.err[0] | (|((bus.c_vec_en | bus.c_rot_en) & ~own));
    err_nx[1] = bus.err[1]
              | (bus.vec_opvld_in && vec_cnt == '0)
              | (bus.rot_opvld_in && rot_cnt == '0);
    err_nx[2] = bus.err[2] | wd_fire
              | (vec_iss && !vec_ret && vec_cnt == CMAX)
              | (rot_iss && !rot_ret && rot_cnt == CMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= IDLE;
      owner                    <= '0;
      last_owner               <= IW'(NC - 1);
      vec_cnt                  <= '0;
      rot_cnt                  <= '0;
      bus.gnt                  <= '0;
      bus.err                  <= '0;
      bus.vec_en               <= 1'b0;
      bus.vec_xin              <= '0;
      bus.vec_yin              <= '0;
      bus.vec_angle_calc_en    <= 1'b0;
      bus.rot_en               <= 1'b0;
      bus.rot_xin              <= '0;
      bus.rot_yin              <= '0;
      bus.rot_angle_in         <= '0;
      bus.rot_angle_microRot_n <= 1'b0;
      bus.rot_quad_in          <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_nx;
      vec_cnt    <= vec_cnt_nx;
      rot_cnt    <= rot_cnt_nx;
      bus.gnt    <= gnt_nx;
      bus.err    <= err_nx;
      bus.vec_en <= vec_iss;
      bus.rot_en <= rot_iss;
      if (active) begin
        bus.vec_xin <= bus.c_vec_xin[owner*DATA_WIDTH +: DATA_WIDTH];
        bus.vec_yin <= bus.c_vec_yin[owner*DATA_WIDTH +: DATA_WIDTH];
        bus.vec_angle_calc_en <= bus.c_vec_angle_calc_en[owner];
        bus.rot_xin <= bus.c_rot_xin[owner*DATA_WIDTH +: DATA_WIDTH];
        bus.rot_yin <= bus.c_rot_yin[owner*DATA_WIDTH +: DATA_WIDTH];
        bus.rot_angle_in <=
          bus.c_rot_angle_in[owner*ANGLE_WIDTH +: ANGLE_WIDTH];
        bus.rot_angle_microRot_n <= bus.c_rot_angle_microRot_n[owner];
        bus.rot_quad_in <= bus.c_rot_quad_in[owner*2 +: 2];
      end
    end
  end
endmodule

// File: tb/tb_cordic_share_arb.sv
// Directed bench for cordic_share_arb with a forwarded-operand scoreboard.
// Default build (no watchdog), NC=2, 16-bit data and angle, CNT_WIDTH=5.
module tb_cordic_share_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [63:0] vq[$];
  logic [63:0] rq[$];
  logic [63:0] e;

  cordic_share_arb_if #(.NC(2), .DATA_WIDTH(16), .ANGLE_WIDTH(16)) bus();

  cordic_share_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("vec_en", bus.vec_en, 64'(vq.size() != 0));
    if (bus.vec_en && vq.size() != 0) begin
      e = vq.pop_front();
      chk("vec_ops", {bus.vec_xin, bus.vec_yin, bus.vec_angle_calc_en}, e);
    end
    chk("rot_en", bus.rot_en, 64'(rq.size() != 0));
    if (bus.rot_en && rq.size() != 0) begin
      e = rq.pop_front();
      chk("rot_ops", {bus.rot_xin, bus.rot_yin, bus.rot_angle_in,
                      bus.rot_angle_microRot_n, bus.rot_quad_in}, e);
    end
  endtask

  task automatic vec_issue(input int c, input logic [15:0] x,
                           input logic [15:0] y, input logic ace,
                           input bit expect_fwd);
    bus.c_vec_en[c] = 1'b1;
    bus.c_vec_xin[c*16 +: 16] = x;
    bus.c_vec_yin[c*16 +: 16] = y;
    bus.c_vec_angle_calc_en[c] = ace;
    if (expect_fwd) vq.push_back(64'({x, y, ace}));
  endtask

  task automatic rot_issue(input int c, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] a,
                           input logic m, input logic [1:0] q);
    bus.c_rot_en[c] = 1'b1;
    bus.c_rot_xin[c*16 +: 16] = x;
    bus.c_rot_yin[c*16 +: 16] = y;
    bus.c_rot_angle_in[c*16 +: 16] = a;
    bus.c_rot_angle_microRot_n[c] = m;
    bus.c_rot_quad_in[c*2 +: 2] = q;
    rq.push_back(64'({x, y, a, m, q}));
  endtask

  initial begin
    bus.req = '0;
    bus.c_vec_en = '0;
    bus.c_vec_xin = '0;
    bus.c_vec_yin = '0;
    bus.c_vec_angle_calc_en = '0;
    bus.c_rot_en = '0;
    bus.c_rot_xin = '0;
    bus.c_rot_yin = '0;
    bus.c_rot_angle_in = '0;
    bus.c_rot_angle_microRot_n = '0;
    bus.c_rot_quad_in = '0;
    bus.vec_opvld_in = 1'b0;
    bus.rot_opvld_in = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.err, 3'b000);
    chk("rst_vec_en", bus.vec_en, 1'b0);
    chk("rst_rot_en", bus.rot_en, 1'b0);
    chk("rst_vec_xin", bus.vec_xin, 16'h0);
    rst_n = 1'b1;

    // first session: client 0, vectoring op and its return
    bus.req = 2'b01;
    tick();
    chk("gnt_c0", bus.gnt, 2'b01);
    chk("busy_c0", bus.busy, 1'b1);
    vec_issue(0, 16'h0400, 16'h0200, 1'b1, 1'b1);
    tick();
    bus.c_vec_en = '0;
    bus.vec_opvld_in = 1'b1;
    #1;
    chk("vec_route_c0", bus.c_vec_opvld, 2'b01);
    tick();
    bus.vec_opvld_in = 1'b0;

    // client 1 requests and issues without a grant
    bus.req = 2'b11;
    vec_issue(1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    bus.c_vec_en = '0;
    chk("err_nonowner", bus.err, 3'b001);
    chk("gnt_wait", bus.gnt, 2'b01);

    // stray return with vec_cnt at zero
    bus.vec_opvld_in = 1'b1;
    #1;
    chk("stray_route", bus.c_vec_opvld, 2'b00);
    tick();
    bus.vec_opvld_in = 1'b0;
    chk("err_stray", bus.err, 3'b011);

    // three rotations, req falls with the third
    for (int i = 0; i < 3; i++) begin
      rot_issue(0, 16'(16'h0100 + i), 16'(16'h7f00 - i),
                16'(16'h2000 * (i + 1)), i[0], 2'(i));
      if (i == 2) bus.req[0] = 1'b0;
      tick();
      bus.c_rot_en = '0;
    end
    chk("drain_gnt", bus.gnt, 2'b01);
    for (int i = 0; i < 2; i++) begin
      bus.rot_opvld_in = 1'b1;
      #1;
      chk("rot_route_c0", bus.c_rot_opvld, 2'b01);
      tick();
      bus.rot_opvld_in = 1'b0;
    end
    tick();
    chk("drain_hold_gnt", bus.gnt, 2'b01);
    chk("drain_hold_busy", bus.busy, 1'b1);
    bus.rot_opvld_in = 1'b1;
    #1;
    chk("rot_route_last", bus.c_rot_opvld, 2'b01);
    tick();
    bus.rot_opvld_in = 1'b0;
    chk("drain_last_gnt", bus.gnt, 2'b01);
    tick();
    chk("idle_gnt", bus.gnt, 2'b00);
    chk("idle_busy", bus.busy, 1'b0);
    tick();
    chk("rr_gnt_c1", bus.gnt, 2'b10);

    // client 1 session
    rot_issue(1, 16'hbeef, 16'h1234, 16'h5a5a, 1'b1, 2'b11);
    tick();
    bus.c_rot_en = '0;
    bus.rot_opvld_in = 1'b1;
    #1;
    chk("rot_route_c1", bus.c_rot_opvld, 2'b10);
    tick();
    bus.rot_opvld_in = 1'b0;
    bus.req = 2'b00;
    tick();
    tick();
    chk("idle_after_c1", bus.gnt, 2'b00);
    bus.req = 2'b11;
    tick();
    chk("rr_gnt_c0", bus.gnt, 2'b01);

    // saturate vec_cnt (limit 31) with 32 back-to-back issues
    for (int i = 0; i < 32; i++) begin
      vec_issue(0, 16'(i * 3 + 1), 16'(i), i[0], 1'b1);
      tick();
    end
    bus.c_vec_en = '0;
    tick();
    chk("err_sat", bus.err, 3'b111);
    bus.vec_opvld_in = 1'b1;
    #1;
    chk("sat_route", bus.c_vec_opvld, 2'b01);
    repeat (31) tick();
    chk("sat_empty_route", bus.c_vec_opvld, 2'b00);
    bus.vec_opvld_in = 1'b0;

    // reset mid-session with one op outstanding
    vec_issue(0, 16'h0abc, 16'h0def, 1'b0, 1'b1);
    tick();
    bus.c_vec_en = '0;
    bus.req = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", bus.gnt, 2'b00);
    chk("mid_rst_err", bus.err, 3'b000);
    chk("mid_rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    bus.vec_opvld_in = 1'b1;
    #1;
    chk("late_route", bus.c_vec_opvld, 2'b00);
    tick();
    bus.vec_opvld_in = 1'b0;
    chk("late_err", bus.err, 3'b010);

    chk("vq_empty", 64'(vq.size()), 64'd0);
    chk("rq_empty", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cordic_share_arb.md
Name: cordic_share_arb

Overview:
- Shares one vectoring CORDIC and one rotation CORDIC (rot1) between NC requesters, for example the update engine and the orthogonalisation engine.
- Round-robin session arbitration. A granted client owns both cores until it releases and all its in-flight operations have returned.
- Muxes the granted client's operands onto the cores and routes the valid strobes back to the owner only.
- Sits between the client engines and the CORDIC core instances in the ICA top.

Parameters:
- NC, 2, number of requesting clients (2..4).
- DATA_WIDTH, 16, CORDIC operand width.
- ANGLE_WIDTH, 16, rotation angle width.
- CNT_WIDTH, 5, width of each outstanding-operation counter; the saturation limit is 2^CNT_WIDTH-1.
- TIMEOUT, 1023, drain watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NC  per-client session request; held high for the whole session.
- gnt  out  NC  one-hot grant, registered.
- c_vec_en  in  NC  per-client vectoring issue strobe.
- c_vec_xin / c_vec_yin  in  NC*DATA_WIDTH  per-client vectoring operands, packed with client i at [i*DATA_WIDTH +: DATA_WIDTH].
- c_vec_angle_calc_en  in  NC  per-client angle-calculation enable.
- c_rot_en  in  NC  per-client rotation issue strobe.
- c_rot_xin / c_rot_yin  in  NC*DATA_WIDTH  per-client rotation operands.
- c_rot_angle_in  in  NC*ANGLE_WIDTH  per-client rotation angle.
- c_rot_angle_microRot_n  in  NC  per-client angle/micro-rotation select.
- c_rot_quad_in  in  NC*2  per-client quadrant.
- vec_en, vec_xin, vec_yin, vec_angle_calc_en  out  1/DW/DW/1  to the vectoring CORDIC, registered.
- rot_en, rot_xin, rot_yin, rot_angle_in, rot_angle_microRot_n, rot_quad_in  out  1/DW/DW/AW/1/2  to the rotation CORDIC, registered.
- vec_opvld_in, rot_opvld_in  in  1  valid strobes from the cores.
- c_vec_opvld, c_rot_opvld  out  NC  valid strobes routed to the owner, combinational (same cycle as the core strobe).
- busy  out  1  high when the state is not IDLE.
- err  out  3  sticky flags: [0] issue from a non-owner, [1] opvld received with its counter at 0, [2] counter saturated or watchdog fired.

Behaviour:
- Reset: every output is 0, state is IDLE, last_owner is NC-1, both counters and err are 0.
- State IDLE:
  - If any req bit is high, pick the first requester scanning from last_owner+1 with wrap-around.
  - Set gnt for that client on the next edge and move to GRANT.
  - Minimum latency is 1 cycle from req to gnt.
- State GRANT:
  - Owner's c_*_en and operands are registered onto the core ports (1-cycle latency).
  - Core enables are 1-cycle pulses that mirror the owner's strobes.
  - When the owner drops req, move to DRAIN. Enables seen in the same cycle that req falls are still forwarded.
- State DRAIN:
  - gnt stays high; new enables from the owner are still forwarded and counted.
  - Move to IDLE when req is still low and vec_cnt==0 and rot_cnt==0.
  - On that transition, clear gnt and set last_owner to the owner.
  - If the owner re-raises req during DRAIN, return to GRANT with no re-arbitration.
- Counters:
  - vec_cnt increments on a forwarded vec issue and decrements on vec_opvld_in.
  - A simultaneous issue and return leaves the count unchanged. rot_cnt behaves the same way.
  - An issue while a counter is saturated is still forwarded, the count holds, and err[2] is set.
  - An opvld while the counter is 0 does not decrement, is not routed, and sets err[1].
- Non-owner enables are never forwarded and set err[0]. A client with req high and no gnt waits.
- While the state is IDLE, core enables are 0 and operand registers hold their last values.
- Reset mid-session: everything returns to reset values immediately, and in-flight returns afterwards trip err[1].

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined: a watchdog counts cycles spent in DRAIN. When it reaches TIMEOUT, the arbiter forces IDLE, clears both counters and gnt, sets err[2], and updates last_owner.
- When undefined: no watchdog, and DRAIN waits indefinitely.

Test Plan:
- req=01 at cycle 0 -> gnt=01 at cycle 1; c_vec_en[0] pulse with xin=0x0400, yin=0x0200 -> vec_en=1, vec_xin=0x0400, vec_yin=0x0200 one cycle later.
- Both req high from reset -> gnt=01. Client 0 drops req with counters at 0 -> gnt=00 for one cycle in IDLE, then gnt=10 (round-robin).
- Owner issues 3 rot ops, drops req, 2 rot_opvld_in arrive -> still DRAIN with gnt held. 3rd opvld -> c_rot_opvld[0] pulses, then IDLE.
- Non-owner pulses c_vec_en[1] during client 0's session -> vec_en stays 0 and err=3'b001.
- vec_opvld_in with vec_cnt=0 -> c_vec_opvld=00 and err[1]=1. With ARB_TIMEOUT_EN and TIMEOUT=15, an owner in DRAIN with 1 missing opvld -> IDLE after 15 cycles and err[2]=1.
